// File: rtl/load_store_unit_if.sv
// ---------------------------------------------------------------------------
// load_store_unit_if
// Data-memory port of the load/store unit: a valid/ready request channel
// and a valid-only load response channel.
//   MemReqValid / MemReqReady : request handshake
//   MemReqWrite               : 1 = store, 0 = load
//   MemReqAddr                : 8-byte-aligned address
//   MemReqWData / MemReqMask  : lane-steered store data and byte write mask
//   MemRespValid / MemRespRData : 8-byte-aligned load data
// The master modport is the LSU side, the slave modport is the memory side.
// ---------------------------------------------------------------------------
interface load_store_unit_if #(
  parameter int ADDR_W = 64
) ();

  logic              MemReqValid;
  logic              MemReqReady;
  logic              MemReqWrite;
  logic [ADDR_W-1:0] MemReqAddr;
  logic [63:0]       MemReqWData;
  logic [7:0]        MemReqMask;
  logic              MemRespValid;
  logic [63:0]       MemRespRData;

  modport master (
    output MemReqValid,
    output MemReqWrite,
    output MemReqAddr,
    output MemReqWData,
    output MemReqMask,
    input  MemReqReady,
    input  MemRespValid,
    input  MemRespRData
  );

  modport slave (
    input  MemReqValid,
    input  MemReqWrite,
    input  MemReqAddr,
    input  MemReqWData,
    input  MemReqMask,
    output MemReqReady,
    output MemRespValid,
    output MemRespRData
  );

endinterface

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
// Memory stage of the RV64I pipeline. Non-memory instructions pass their
// writeback straight through. Loads and stores stall the pipeline via
// HoldFlagToCtrl, run one request on the data-memory port, steer byte lanes
// and sign/zero-extend load data, then present the writeback for one cycle.
// Misaligned or illegal accesses are dropped with a one-cycle error pulse.
//   Clk, Rst_n            : clock, asynchronous active-low reset
//   OpCodeIn .. RdWriteEnableIn : operands forwarded from execute
//   RdWriteDataOut/RdAddrOut/RdWriteEnableOut : register writeback
//   HoldFlagToCtrl        : stall request to Ctrl
//   MisalignErrOut        : dropped-access pulse
//   memBus                : data-memory port (master side)
// ---------------------------------------------------------------------------
module load_store_unit #(
  parameter int ADDR_W = 64
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic [6:0]  OpCodeIn,
  input  logic [2:0]  Funct3In,
  input  logic [63:0] ImmIn,
  input  logic [63:0] Rs1ReadDataIn,
  input  logic [63:0] Rs2ReadDataIn,
  input  logic [63:0] RdWriteDataIn,
  input  logic [4:0]  RdAddrIn,
  input  logic        RdWriteEnableIn,
  output logic [63:0] RdWriteDataOut,
  output logic [4:0]  RdAddrOut,
  output logic        RdWriteEnableOut,
  output logic        HoldFlagToCtrl,
  output logic        MisalignErrOut,
  load_store_unit_if.master memBus
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP,
    DONE
  } lsuState_t;

  lsuState_t state, stateNext;

  logic        isLoadOp, isStoreOp, isMemOp;
  logic [63:0] effAddr;
  logic [2:0]  effOff;
  logic [7:0]  sizeMask;
  logic [2:0]  alignMask;
  logic        illegalOp, misaligned;

  logic [63:0] eaReg;
  logic [2:0]  funct3Reg;
  logic [4:0]  rdAddrReg;
  logic        writeReg;
  logic        errReg;
  logic [63:0] wDataReg;
  logic [7:0]  maskReg;
  logic [63:0] loadDataReg;

  logic [63:0] respShifted;
  logic [63:0] respExtended;

  // Decode of the instruction currently offered by execute.
  assign isLoadOp  = (OpCodeIn == OP_LOAD);
  assign isStoreOp = (OpCodeIn == OP_STORE);
  assign isMemOp   = isLoadOp | isStoreOp;
  assign effAddr   = Rs1ReadDataIn + ImmIn;
  assign effOff    = effAddr[2:0];

  // Access size as a byte mask and as the offset bits that must be zero.
  always_comb begin
    sizeMask  = 8'h01;
    alignMask = 3'b000;
    case (Funct3In[1:0])
      2'd0: begin sizeMask = 8'h01; alignMask = 3'b000; end
      2'd1: begin sizeMask = 8'h03; alignMask = 3'b001; end
      2'd2: begin sizeMask = 8'h0F; alignMask = 3'b011; end
      2'd3: begin sizeMask = 8'hFF; alignMask = 3'b111; end
      default: ;
    endcase
  end

  assign misaligned = ((effOff & alignMask) != 3'b000);
  assign illegalOp  = isLoadOp ? (Funct3In == 3'b111) : Funct3In[2];

  // Response lane steering and extension, driven by the latched access.
  assign respShifted = memBus.MemRespRData >> {eaReg[2:0], 3'b000};

  always_comb begin
    respExtended = '0;
    case (funct3Reg)
      3'b000: respExtended = {{56{respShifted[7]}},  respShifted[7:0]};
      3'b001: respExtended = {{48{respShifted[15]}}, respShifted[15:0]};
      3'b010: respExtended = {{32{respShifted[31]}}, respShifted[31:0]};
      3'b011: respExtended = respShifted;
      3'b100: respExtended = {56'd0, respShifted[7:0]};
      3'b101: respExtended = {48'd0, respShifted[15:0]};
      3'b110: respExtended = {32'd0, respShifted[31:0]};
      default: respExtended = '0;
    endcase
  end

  // State register; reset drops any in-flight access immediately.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Access context is captured once in IDLE so the request payload stays
  // stable no matter what execute does while we hold the pipeline.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      eaReg       <= '0;
      funct3Reg   <= '0;
      rdAddrReg   <= '0;
      writeReg    <= 1'b0;
      errReg      <= 1'b0;
      wDataReg    <= '0;
      maskReg     <= '0;
      loadDataReg <= '0;
    end else begin
      if (state == IDLE && isMemOp) begin
        eaReg       <= effAddr;
        funct3Reg   <= Funct3In;
        rdAddrReg   <= RdAddrIn;
        writeReg    <= isStoreOp;
        errReg      <= illegalOp | misaligned;
        wDataReg    <= isStoreOp ? (Rs2ReadDataIn << {effOff, 3'b000}) : 64'd0;
        maskReg     <= isStoreOp ? (sizeMask << effOff) : 8'd0;
        loadDataReg <= '0;
      end
      if (state == RESP && memBus.MemRespValid) begin
        loadDataReg <= respExtended;
      end
    end
  end

  // Next-state and pipeline-facing outputs. DONE always returns to IDLE so
  // the completed instruction, still on the inputs, is not restarted.
  always_comb begin
    stateNext        = state;
    RdWriteDataOut   = '0;
    RdAddrOut        = '0;
    RdWriteEnableOut = 1'b0;
    HoldFlagToCtrl   = 1'b0;
    MisalignErrOut   = 1'b0;
    case (state)
      IDLE: begin
        if (isMemOp) begin
          HoldFlagToCtrl = 1'b1;
          stateNext      = (illegalOp | misaligned) ? DONE : REQ;
        end else begin
          RdWriteDataOut   = RdWriteDataIn;
          RdAddrOut        = RdAddrIn;
          RdWriteEnableOut = RdWriteEnableIn;
        end
      end
      REQ: begin
        HoldFlagToCtrl = 1'b1;
        if (memBus.MemReqReady) begin
          stateNext = writeReg ? DONE : RESP;
        end
      end
      RESP: begin
        HoldFlagToCtrl = 1'b1;
        if (memBus.MemRespValid) begin
          stateNext = DONE;
        end
      end
      DONE: begin
        stateNext      = IDLE;
        MisalignErrOut = errReg;
        if (!writeReg && !errReg) begin
          RdWriteDataOut   = loadDataReg;
          RdAddrOut        = rdAddrReg;
          RdWriteEnableOut = 1'b1;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  assign memBus.MemReqValid = (state == REQ);
  assign memBus.MemReqWrite = writeReg;
  assign memBus.MemReqAddr  = {eaReg[ADDR_W-1:3], 3'b000};
  assign memBus.MemReqWData = wDataReg;
  assign memBus.MemReqMask  = maskReg;

endmodule

// File: tb/tb_load_store_unit.sv
// ---------------------------------------------------------------------------
// tb_load_store_unit
// Self-checking bench for load_store_unit: directed cases followed by
// randomized instructions, all compared against a byte-level reference
// model of the memory stage.
// ---------------------------------------------------------------------------
module tb_load_store_unit;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_ALU   = 7'b0110011;

  logic        Clk;
  logic        Rst_n;
  logic [6:0]  OpCodeIn;
  logic [2:0]  Funct3In;
  logic [63:0] ImmIn;
  logic [63:0] Rs1ReadDataIn;
  logic [63:0] Rs2ReadDataIn;
  logic [63:0] RdWriteDataIn;
  logic [4:0]  RdAddrIn;
  logic        RdWriteEnableIn;
  logic [63:0] RdWriteDataOut;
  logic [4:0]  RdAddrOut;
  logic        RdWriteEnableOut;
  logic        HoldFlagToCtrl;
  logic        MisalignErrOut;

  int compareCount;
  int mismatchCount;

  load_store_unit_if #(.ADDR_W(64)) memBus ();

  load_store_unit #(.ADDR_W(64)) dut (
    .Clk              (Clk),
    .Rst_n            (Rst_n),
    .OpCodeIn         (OpCodeIn),
    .Funct3In         (Funct3In),
    .ImmIn            (ImmIn),
    .Rs1ReadDataIn    (Rs1ReadDataIn),
    .Rs2ReadDataIn    (Rs2ReadDataIn),
    .RdWriteDataIn    (RdWriteDataIn),
    .RdAddrIn         (RdAddrIn),
    .RdWriteEnableIn  (RdWriteEnableIn),
    .RdWriteDataOut   (RdWriteDataOut),
    .RdAddrOut        (RdAddrOut),
    .RdWriteEnableOut (RdWriteEnableOut),
    .HoldFlagToCtrl   (HoldFlagToCtrl),
    .MisalignErrOut   (MisalignErrOut),
    .memBus           (memBus)
  );

  // Free-running clock.
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Byte-level reference: legality, store lanes/mask and the loaded value.
  function automatic void refModel(input logic isStore, input logic [2:0] f3,
                                   input logic [63:0] ea, input logic [63:0] rs2,
                                   input logic [63:0] resp, output logic err,
                                   output logic [63:0] wData, output logic [7:0] mask,
                                   output logic [63:0] ldVal);
    int size;
    int off;
    size  = 1 << f3[1:0];
    off   = int'(ea[2:0]);
    err   = (isStore ? f3[2] : (f3 == 3'b111)) || ((off % size) != 0);
    wData = 64'd0;
    mask  = 8'd0;
    ldVal = 64'd0;
    if (isStore) begin
      wData = rs2 << (8 * off);
      for (int b = 0; b < size; b++)
        if (off + b < 8) mask[off + b] = 1'b1;
    end else begin
      for (int b = 0; b < size; b++)
        if (off + b < 8) ldVal[8*b +: 8] = resp[8*(off + b) +: 8];
      if (!f3[2] && size < 8 && ldVal[8*size - 1])
        ldVal = ldVal | (~64'd0 << (8 * size));
    end
  endfunction

  // Runs one instruction from its detect cycle through DONE, playing the
  // memory side with the given delays. Leaves time just after a rising edge.
  task automatic applyStimulus(input logic [6:0] op, input logic [2:0] f3,
                               input logic [63:0] rs1, input logic [63:0] imm,
                               input logic [63:0] rs2, input logic [63:0] rdData,
                               input logic [4:0] rd, input logic we,
                               input int readyDelay, input int respDelay,
                               input logic [63:0] respData, input logic stray);
    logic        isLd, isSt, expErr;
    logic [63:0] ea, expW, expVal;
    logic [7:0]  expMask;
    isLd = (op == OP_LOAD);
    isSt = (op == OP_STORE);
    OpCodeIn        = op;
    Funct3In        = f3;
    Rs1ReadDataIn   = rs1;
    ImmIn           = imm;
    Rs2ReadDataIn   = rs2;
    RdWriteDataIn   = rdData;
    RdAddrIn        = rd;
    RdWriteEnableIn = we;
    @(negedge Clk);
    if (!isLd && !isSt) begin
      checkOutput("passData", RdWriteDataOut, rdData);
      checkOutput("passAddr", 64'(RdAddrOut), 64'(rd));
      checkOutput("passWe", 64'(RdWriteEnableOut), 64'(we));
      checkOutput("passHold", 64'(HoldFlagToCtrl), 64'd0);
      checkOutput("passValid", 64'(memBus.MemReqValid), 64'd0);
      @(posedge Clk); #1;
    end else begin
      ea = rs1 + imm;
      refModel(isSt, f3, ea, rs2, respData, expErr, expW, expMask, expVal);
      checkOutput("detectHold", 64'(HoldFlagToCtrl), 64'd1);
      checkOutput("detectValid", 64'(memBus.MemReqValid), 64'd0);
      checkOutput("detectWe", 64'(RdWriteEnableOut), 64'd0);
      @(posedge Clk); #1;
      if (!expErr) begin
        for (int c = 0; c <= readyDelay; c++) begin
          memBus.MemReqReady  = (c == readyDelay);
          memBus.MemRespValid = stray;
          memBus.MemRespRData = {$urandom, $urandom};
          @(negedge Clk);
          checkOutput("reqValid", 64'(memBus.MemReqValid), 64'd1);
          checkOutput("reqHold", 64'(HoldFlagToCtrl), 64'd1);
          checkOutput("reqWe", 64'(RdWriteEnableOut), 64'd0);
          checkOutput("reqAddr", memBus.MemReqAddr, {ea[63:3], 3'b000});
          checkOutput("reqWrite", 64'(memBus.MemReqWrite), 64'(isSt));
          checkOutput("reqMask", 64'(memBus.MemReqMask), 64'(expMask));
          if (isSt) checkOutput("reqWData", memBus.MemReqWData, expW);
          @(posedge Clk); #1;
        end
        memBus.MemReqReady  = 1'b0;
        memBus.MemRespValid = 1'b0;
        if (isLd) begin
          for (int c = 0; c <= respDelay; c++) begin
            memBus.MemRespValid = (c == respDelay);
            memBus.MemRespRData = (c == respDelay) ? respData : {$urandom, $urandom};
            @(negedge Clk);
            checkOutput("respValid", 64'(memBus.MemReqValid), 64'd0);
            checkOutput("respHold", 64'(HoldFlagToCtrl), 64'd1);
            checkOutput("respWe", 64'(RdWriteEnableOut), 64'd0);
            @(posedge Clk); #1;
          end
          memBus.MemRespValid = 1'b0;
        end
      end
      @(negedge Clk);
      checkOutput("doneHold", 64'(HoldFlagToCtrl), 64'd0);
      checkOutput("doneErr", 64'(MisalignErrOut), 64'(expErr));
      checkOutput("doneValid", 64'(memBus.MemReqValid), 64'd0);
      checkOutput("doneWe", 64'(RdWriteEnableOut), 64'(isLd && !expErr));
      checkOutput("doneData", RdWriteDataOut, (isLd && !expErr) ? expVal : 64'd0);
      if (isLd && !expErr) checkOutput("doneAddr", 64'(RdAddrOut), 64'(rd));
      @(posedge Clk); #1;
      OpCodeIn        = OP_ALU;
      RdWriteEnableIn = 1'b0;
    end
  endtask

  initial begin
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [63:0] rs1, imm, sizeM1;
    compareCount  = 0;
    mismatchCount = 0;
    Rst_n           = 1'b0;
    OpCodeIn        = 7'd0;
    Funct3In        = 3'd0;
    ImmIn           = 64'd0;
    Rs1ReadDataIn   = 64'd0;
    Rs2ReadDataIn   = 64'd0;
    RdWriteDataIn   = 64'd0;
    RdAddrIn        = 5'd0;
    RdWriteEnableIn = 1'b0;
    memBus.MemReqReady  = 1'b0;
    memBus.MemRespValid = 1'b0;
    memBus.MemRespRData = 64'd0;

    // Reset state.
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    checkOutput("rstValid", 64'(memBus.MemReqValid), 64'd0);
    checkOutput("rstWrite", 64'(memBus.MemReqWrite), 64'd0);
    checkOutput("rstAddr", memBus.MemReqAddr, 64'd0);
    checkOutput("rstWData", memBus.MemReqWData, 64'd0);
    checkOutput("rstMask", 64'(memBus.MemReqMask), 64'd0);
    checkOutput("rstErr", 64'(MisalignErrOut), 64'd0);
    checkOutput("rstHold", 64'(HoldFlagToCtrl), 64'd0);
    @(posedge Clk); #1;
    Rst_n = 1'b1;

    // Directed cases.
    applyStimulus(OP_ALU, 3'd0, 64'd0, 64'd0, 64'd0, 64'h1234, 5'd5, 1'b1,
                  0, 0, 64'd0, 1'b0);
    applyStimulus(OP_LOAD, 3'b000, 64'h1000, 64'd3, 64'd0, 64'd0, 5'd7, 1'b1,
                  0, 0, 64'h0000_0000_8000_0000, 1'b0);
    applyStimulus(OP_LOAD, 3'b100, 64'h1000, 64'd3, 64'd0, 64'd0, 5'd8, 1'b1,
                  0, 0, 64'h0000_0000_8000_0000, 1'b0);
    applyStimulus(OP_STORE, 3'b001, 64'h2002, 64'd0, 64'hABCD, 64'd0, 5'd0, 1'b0,
                  3, 0, 64'd0, 1'b0);
    applyStimulus(OP_LOAD, 3'b010, 64'h3006, 64'd0, 64'd0, 64'd0, 5'd9, 1'b1,
                  0, 0, 64'd0, 1'b0);
    applyStimulus(OP_LOAD, 3'b011, 64'h5000, 64'd8, 64'd0, 64'd0, 5'd10, 1'b1,
                  2, 5, 64'hDEAD_BEEF_0123_4567, 1'b1);
    applyStimulus(OP_STORE, 3'b100, 64'h6000, 64'd0, 64'h55, 64'd0, 5'd0, 1'b0,
                  0, 0, 64'd0, 1'b0);
    applyStimulus(OP_LOAD, 3'b111, 64'h6000, 64'd0, 64'd0, 64'd0, 5'd3, 1'b1,
                  0, 0, 64'd0, 1'b0);

    // Reset while waiting for a load response.
    OpCodeIn = OP_LOAD; Funct3In = 3'b011; Rs1ReadDataIn = 64'h4000; ImmIn = 64'd0;
    RdAddrIn = 5'd12; RdWriteEnableIn = 1'b1;
    memBus.MemReqReady = 1'b1;
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    memBus.MemReqReady = 1'b0;
    @(negedge Clk);
    checkOutput("midRespHold", 64'(HoldFlagToCtrl), 64'd1);
    Rst_n = 1'b0;
    OpCodeIn = OP_ALU; RdWriteDataIn = 64'h55; RdWriteEnableIn = 1'b0;
    #1;
    checkOutput("asyncRstValid", 64'(memBus.MemReqValid), 64'd0);
    checkOutput("asyncRstHold", 64'(HoldFlagToCtrl), 64'd0);
    @(posedge Clk); #1;
    Rst_n = 1'b1;
    memBus.MemRespValid = 1'b1;
    memBus.MemRespRData = 64'hFFFF_0000_FFFF_0000;
    for (int c = 0; c < 2; c++) begin
      @(negedge Clk);
      checkOutput("lateRespWe", 64'(RdWriteEnableOut), 64'd0);
      checkOutput("lateRespData", RdWriteDataOut, 64'h55);
      checkOutput("lateRespHold", 64'(HoldFlagToCtrl), 64'd0);
      @(posedge Clk); #1;
    end
    memBus.MemRespValid = 1'b0;

    // Randomized instruction mix, mostly aligned accesses.
    for (int n = 0; n < 300; n++) begin
      case ($urandom % 5)
        0, 1:    op = OP_LOAD;
        2, 3:    op = OP_STORE;
        default: op = OP_ALU;
      endcase
      f3     = 3'($urandom % 8);
      rs1    = {$urandom, $urandom};
      imm    = 64'($signed(32'($urandom_range(0, 64)) - 32'sd32));
      sizeM1 = (64'd1 << f3[1:0]) - 64'd1;
      if (($urandom % 4) != 0) rs1 = rs1 - ((rs1 + imm) & sizeM1);
      applyStimulus(op, f3, rs1, imm, {$urandom, $urandom}, {$urandom, $urandom},
                    5'($urandom % 32), 1'($urandom % 2),
                    int'($urandom % 4), int'($urandom % 4),
                    {$urandom, $urandom}, 1'($urandom % 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
